// File: rtl/ram_sequencer.sv
// ram_sequencer: burst controller that owns the address, dataIn and RW
// inputs of a 16x32 combinational RAM.
// Ports:
//   clk, reset          clock and asynchronous active-high reset
//   req_valid/req_ready burst request handshake; req_write, req_addr, req_len
//                       (length minus one) describe the burst
//   wr_data/wr_valid/wr_ready   write word stream (consumed in W_WAIT)
//   rd_data/rd_valid/rd_ready   registered read word stream (stallable)
//   done                one-cycle pulse at burst completion
//   busy                high whenever a burst is in progress
//   ram_address, ram_dataIn, ram_RW   registered RAM controls
//   ram_dataOut         combinational RAM read data
// Writes are phased setup / strobe / hold so RW is only high while address
// and data are stable.
module ram_sequencer #(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [3:0]    req_len,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_valid,
    output logic          wr_ready,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic          done,
    output logic          busy,
    output logic [AW-1:0] ram_address,
    output logic [DW-1:0] ram_dataIn,
    output logic          ram_RW,
    input  logic [DW-1:0] ram_dataOut
);

    localparam int unsigned LW = 4;

    typedef enum logic [2:0] {
        IDLE,
        W_WAIT,
        W_STROBE,
        W_HOLD,
        R_ADDR,
        R_OUT
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [LW-1:0] rem_q, rem_d;
    logic [DW-1:0] din_q, din_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;
    logic          done_q, done_d;
    logic          rw_q;
    logic          req_ready_q;
    logic          wr_ready_q;
    logic          busy_q;

    // Next-state and datapath update for the burst sequencer.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        din_d    = din_q;
        rdata_d  = rdata_q;
        rvalid_d = rvalid_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                // req_ready is high exactly in IDLE, so req_valid alone accepts.
                if (req_valid) begin
                    addr_d  = req_addr;
                    rem_d   = req_len;
                    state_d = req_write ? W_WAIT : R_ADDR;
                end
            end
            W_WAIT: begin
                if (wr_valid) begin
                    din_d   = wr_data;
                    state_d = W_STROBE;
                end
            end
            W_STROBE: begin
                state_d = W_HOLD;
            end
            W_HOLD: begin
                if (rem_q == LW'(0)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    addr_d  = addr_q + AW'(1);
                    rem_d   = rem_q - LW'(1);
                    state_d = W_WAIT;
                end
            end
            R_ADDR: begin
                // Address has been stable for a full cycle; capture RAM output.
                rdata_d  = ram_dataOut;
                rvalid_d = 1'b1;
                state_d  = R_OUT;
            end
            R_OUT: begin
                if (rvalid_q && rd_ready) begin
                    rvalid_d = 1'b0;
                    if (rem_q == LW'(0)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        addr_d  = addr_q + AW'(1);
                        rem_d   = rem_q - LW'(1);
                        state_d = R_ADDR;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; status flags are decoded from the next state
    // so they line up with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            din_q       <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            done_q      <= 1'b0;
            rw_q        <= 1'b0;
            req_ready_q <= 1'b1;
            wr_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            din_q       <= din_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
            done_q      <= done_d;
            rw_q        <= (state_d == W_STROBE);
            req_ready_q <= (state_d == IDLE);
            wr_ready_q  <= (state_d == W_WAIT);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign req_ready   = req_ready_q;
    assign wr_ready    = wr_ready_q;
    assign rd_data     = rdata_q;
    assign rd_valid    = rvalid_q;
    assign done        = done_q;
    assign busy        = busy_q;
    assign ram_address = addr_q;
    assign ram_dataIn  = din_q;
    assign ram_RW      = rw_q;

endmodule

// File: tb/tb_ram_sequencer.sv
// Self-checking bench for ram_sequencer: a RAM model, a reference memory image
// updated per completed burst, and directed plus randomized bursts.
module tb_ram_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [3:0]  req_addr;
    logic [3:0]  req_len;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic        done;
    logic        busy;
    logic [3:0]  ram_address;
    logic [31:0] ram_dataIn;
    logic        ram_RW;
    logic [31:0] ram_dataOut;

    ram_sequencer #(.AW(4), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .done(done), .busy(busy),
        .ram_address(ram_address), .ram_dataIn(ram_dataIn), .ram_RW(ram_RW),
        .ram_dataOut(ram_dataOut)
    );

    always #5 clk = ~clk;

    // 16x32 RAM attached to the sequencer
    logic [31:0] tb_ram [16];
    assign ram_dataOut = tb_ram[ram_address];
    always @(posedge clk) if (ram_RW) tb_ram[ram_address] <= ram_dataIn;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // reference memory image, known[] marks locations with defined content
    logic [31:0] exp_mem [16];
    bit          known   [16];
    logic [31:0] wbuf    [16];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // strobe monitor: RW lasts one cycle and address/data are held into W_HOLD
    bit          pend = 0;
    bit          rw_last = 0;
    int          rw_rises = 0;
    logic [3:0]  p_addr;
    logic [31:0] p_din;
    always @(negedge clk) begin
        if (reset) begin
            pend = 0;
        end else begin
            if (pend) begin
                chk("rw_one_cycle", 64'(ram_RW), 64'd0);
                chk("strobe_hold_stable", {28'd0, ram_address, ram_dataIn}, {28'd0, p_addr, p_din});
                pend = 0;
            end
            if (ram_RW) begin
                if (!rw_last) rw_rises++;
                pend   = 1;
                p_addr = ram_address;
                p_din  = ram_dataIn;
            end
        end
        rw_last = ram_RW;
    end

    task automatic send_req(input bit w, input logic [3:0] a, input logic [3:0] l, output int acc);
        int n = 0;
        while (!req_ready && n < 60) begin step(); n++; end
        chk("req_ready_wait", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_write = w; req_addr = a; req_len = l;
        step();
        acc = cyc;
        req_valid = 1'b0; req_write = 1'($urandom); req_addr = 4'($urandom); req_len = 4'($urandom);
        chk("busy_after_accept", 64'(busy), 64'd1);
        chk("addr_loaded", 64'(ram_address), 64'(a));
    endtask

    task automatic wr_word(input logic [31:0] d, input int gap, input bit junk);
        int n = 0;
        while (!wr_ready && n < 60) begin
            wr_valid = junk ? 1'($urandom) : 1'b0;
            wr_data  = $urandom;
            step(); n++;
        end
        chk("wr_ready_wait", 64'(wr_ready), 64'd1);
        wr_valid = 1'b0;
        repeat (gap) step();
        wr_valid = 1'b1; wr_data = d;
        step();
        wr_valid = 1'b0; wr_data = $urandom;
    endtask

    task automatic wait_done(input bit pulse_chk, output int dc);
        int n = 0;
        while (!done && n < 60) begin step(); n++; end
        chk("done_seen", 64'(done), 64'd1);
        chk("req_ready_at_done", 64'(req_ready), 64'd1);
        dc = cyc;
        if (pulse_chk) begin
            step();
            chk("done_one_cycle", 64'(done), 64'd0);
            chk("idle_busy", 64'(busy), 64'd0);
        end
    endtask

    task automatic do_write(input logic [3:0] a, input logic [3:0] l, input int gapmax,
                            input bit junk, input bit pulse_chk, output int acc, output int dc);
        send_req(1'b1, a, l, acc);
        for (int i = 0; i <= int'(l); i++)
            wr_word(wbuf[i], (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0, junk);
        wait_done(pulse_chk, dc);
        for (int i = 0; i <= int'(l); i++) begin
            logic [3:0] ea;
            ea = a + 4'(i);
            exp_mem[ea] = wbuf[i];
            known[ea]   = 1;
            chk("ram_word", 64'(tb_ram[ea]), 64'(wbuf[i]));
        end
    endtask

    task automatic do_read(input logic [3:0] a, input logic [3:0] l, input int stall_word,
                           input int stall_cyc, input bit hold_ready, input bit randstall,
                           input bit pulse_chk, output int acc, output int dc);
        rd_ready = hold_ready ? 1'b1 : 1'($urandom);
        send_req(1'b0, a, l, acc);
        for (int i = 0; i <= int'(l); i++) begin
            int n = 0;
            int s;
            logic [3:0]  ea;
            logic [31:0] saved;
            ea = a + 4'(i);
            if (!hold_ready) rd_ready = 1'b0;
            while (!rd_valid && n < 60) begin step(); n++; end
            chk("rd_valid_wait", 64'(rd_valid), 64'd1);
            if (hold_ready) chk("rd_word_timing", 64'(cyc - acc), 64'(1 + 2 * i));
            if (known[ea]) chk("rd_data", 64'(rd_data), 64'(exp_mem[ea]));
            chk("rd_addr", 64'(ram_address), 64'(ea));
            if (hold_ready) begin
                step();
            end else begin
                s = (i == stall_word) ? stall_cyc : (randstall ? int'($urandom_range(0, 3)) : 0);
                saved = rd_data;
                repeat (s) begin
                    step();
                    chk("stall_valid", 64'(rd_valid), 64'd1);
                    chk("stall_data", 64'(rd_data), 64'(saved));
                    chk("stall_addr", 64'(ram_address), 64'(ea));
                end
                rd_ready = 1'b1;
                step();
                rd_ready = 1'($urandom);
            end
        end
        wait_done(pulse_chk, dc);
        rd_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, dc, r0;
        logic [3:0] ra, rl;
        bit rw;

        reset = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd5; req_len = 4'd2;
        wr_data = '0; wr_valid = 1'b1; rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin exp_mem[i] = '0; known[i] = 0; end

        // reset with a pending request
        repeat (3) step();
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_wr_ready", 64'(wr_ready), 64'd0);
        chk("rst_ram_rw", 64'(ram_RW), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        chk("rst_ram_address", 64'(ram_address), 64'd0);
        chk("rst_ram_dataIn", 64'(ram_dataIn), 64'd0);
        reset = 1'b0; req_valid = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
        step();
        chk("post_rst_idle", 64'(busy), 64'd0);

        // write burst addr 2, len 3
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + 32'(i);
        r0 = rw_rises;
        do_write(4'd2, 4'd3, 0, 0, 1, acc, dc);
        chk("wr_burst_cycles", 64'(dc - acc), 64'd12);
        chk("wr_strobe_count", 64'(rw_rises - r0), 64'd4);

        // read back with rd_ready held high
        do_read(4'd2, 4'd3, -1, 0, 1, 0, 1, acc, dc);
        chk("rd_burst_cycles", 64'(dc - acc), 64'd8);

        // read with a 5-cycle stall on word 1
        do_read(4'd2, 4'd3, 1, 5, 0, 0, 1, acc, dc);

        // wrap-around write 14..1
        for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
        do_write(4'd14, 4'd3, 0, 0, 1, acc, dc);
        chk("wrap_ram14", 64'(tb_ram[14]), 64'h1);
        chk("wrap_ram15", 64'(tb_ram[15]), 64'h2);
        chk("wrap_ram0", 64'(tb_ram[0]), 64'h3);
        chk("wrap_ram1", 64'(tb_ram[1]), 64'h4);
        do_read(4'd14, 4'd3, -1, 0, 1, 0, 1, acc, dc);

        // reset during the strobe of word 2 of a burst at addr 6
        send_req(1'b1, 4'd6, 4'd3, acc);
        wr_word(32'h11, 0, 0);
        wr_word(32'h22, 0, 0);
        exp_mem[6] = 32'h11; known[6] = 1;
        exp_mem[7] = 32'h22; known[7] = 1;
        while (!wr_ready && (cyc - acc) < 40) step();
        wr_valid = 1'b1; wr_data = 32'h33;
        step();
        wr_valid = 1'b0;
        chk("strobe_word2", 64'(ram_RW), 64'd1);
        chk("strobe_word2_addr", 64'(ram_address), 64'd8);
        #2 reset = 1'b1;
        #1;
        chk("rw_async_drop", 64'(ram_RW), 64'd0);
        chk("busy_async_drop", 64'(busy), 64'd0);
        known[8] = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (4) begin
            step();
            chk("no_done_after_abort", 64'(done), 64'd0);
        end
        do_read(4'd2, 4'd3, -1, 0, 1, 0, 1, acc, dc);
        chk("rd_after_abort_cycles", 64'(dc - acc), 64'd8);

        // randomized bursts; first a full 16-word write and read
        for (int t = 0; t < 30; t++) begin
            rw = (t == 0) ? 1'b1 : (t == 1) ? 1'b0 : 1'($urandom);
            ra = 4'($urandom);
            rl = (t < 2) ? 4'd15 : 4'($urandom_range(0, 7));
            if (rw) begin
                for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
                do_write(ra, rl, 2, 1, 1'($urandom), acc, dc);
            end else begin
                do_read(ra, rl, -1, 0, 1'($urandom), 1, 1'($urandom), acc, dc);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_sequencer.md
# ram_sequencer

Bus-side controller that sits directly upstream of the 16x32 combinational RAM and owns its `address`, `dataIn` and `RW` inputs. It accepts burst read/write requests on a valid/ready handshake and sequences them word by word. Writes use a setup/strobe/hold phasing, so `RW` is never high while `address` or `dataIn` changes; read data is returned on a stallable valid/ready stream. This block is the only agent allowed to drive the RAM.

## Interface
Parameters:
- `AW`, 4: RAM address width; fixed to match the 16-word RAM.
- `DW`, 32: data width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `req_valid`  in  1  burst request present.
- `req_ready`  out  1  high only in IDLE; a request is accepted on `req_valid && req_ready`.
- `req_write`  in  1  1 = write burst, 0 = read burst.
- `req_addr`  in  AW  base address.
- `req_len`  in  4  burst length minus 1 (0 → 1 word, 15 → 16 words).
- `wr_data`  in  DW  write word.
- `wr_valid`  in  1  write word present.
- `wr_ready`  out  1  high only in W_WAIT.
- `rd_data`  out  DW  registered read word.
- `rd_valid`  out  1  read word present; held until accepted.
- `rd_ready`  in  1  consumer accepts the read word.
- `done`  out  1  one-cycle pulse when a burst completes.
- `busy`  out  1  high when the state is not IDLE.
- `ram_address`  out  AW  to RAM `address`; registered.
- `ram_dataIn`  out  DW  to RAM `dataIn`; registered.
- `ram_RW`  out  1  to RAM `RW`; registered; 1 = write.
- `ram_dataOut`  in  DW  from RAM `dataOut`.

## Operation
- States: IDLE, W_WAIT, W_STROBE, W_HOLD, R_ADDR, R_OUT.
- Request acceptance in IDLE:
  - Load `ram_address` ← `req_addr` and `remaining` ← `req_len`.
  - Go to W_WAIT if `req_write`, otherwise to R_ADDR.
- W_WAIT:
  - `wr_ready`=1, `ram_RW`=0.
  - On `wr_valid`: `ram_dataIn` ← `wr_data`, go to W_STROBE.
- W_STROBE: `ram_RW`=1 for exactly one cycle; address and data are stable. Go to W_HOLD.
- W_HOLD:
  - `ram_RW`=0; address and data are still held.
  - If `remaining`==0: go to IDLE and pulse `done`.
  - Otherwise: address+1, `remaining`−1, go to W_WAIT.
- R_ADDR:
  - `ram_RW`=0 with the address stable for one cycle.
  - At the end of the cycle: `rd_data` ← `ram_dataOut`, `rd_valid` ← 1, go to R_OUT.
- R_OUT: hold `rd_data` and `rd_valid` until `rd_ready`. On accept:
  - `rd_valid` ← 0.
  - If `remaining`==0: go to IDLE and pulse `done`.
  - Otherwise: address+1, `remaining`−1, go to R_ADDR.
- Address arithmetic is modulo 16. Address 15 increments to 0, so a 16-word burst covers every location exactly once.
- `req_valid` is ignored while busy.
- `wr_valid` is ignored outside W_WAIT; `rd_ready` is ignored while `rd_valid`=0.
- `ram_RW` is asserted only in W_STROBE. It is never high in any cycle in which `ram_address` or `ram_dataIn` changes.

## Timing
- Reset (async, immediate):
  - State → IDLE.
  - `ram_RW`=0, `ram_address`=0, `ram_dataIn`=0, `rd_data`=0, `rd_valid`=0, `done`=0, `busy`=0.
  - `req_ready`=1, `wr_ready`=0.
- Reset mid-burst aborts the burst with no `done`. `ram_RW` falls asynchronously, so a write in progress may or may not land.
- Write: with `wr_valid` held high, a word costs 3 cycles (W_WAIT, W_STROBE, W_HOLD).
  - `ram_RW` rises 2 edges after request acceptance.
- Read: `rd_valid` rises 2 edges after request acceptance.
  - With `rd_ready` held high, a word costs 2 cycles.
- `done` is high in the cycle following the final W_HOLD, or following the final R_OUT accept. `req_ready` is high in that same cycle.
- A new request may be accepted in the same cycle that `done` is high.

## Test plan
- Reset with `req_valid`=1 → `req_ready`=1, `ram_RW`=0, all registered outputs 0; no request accepted until `reset` is released.
- Write burst: addr 2, len 3, data 0xA0..0xA3 → RAM[2..5] = 0xA0..0xA3.
  - `ram_RW` high exactly 4 single cycles.
  - `done` one pulse after 12 cycles.
- Read burst: addr 2, len 3, `rd_ready`=1 → `rd_data` 0xA0, 0xA1, 0xA2, 0xA3, one every 2 cycles; then `done`.
- Read with `rd_ready` low for 5 cycles on word 1 → `rd_valid` and `rd_data` stay stable; `ram_address` does not advance; no word is lost.
- Wrap-around: write addr 14, len 3 (words 0x1..0x4) → RAM[14]=0x1, RAM[15]=0x2, RAM[0]=0x3, RAM[1]=0x4.
- Assert `reset` during W_STROBE of word 2 → `ram_RW` drops immediately; no `done`; a new read of addr 2 then proceeds normally.
